// File: rtl/slave_reg_pkg.sv
// Shared types and constants for the slave_reg register-file bus slave.
package slave_reg_pkg;

    localparam int WORD_BYTES = 4;
    localparam int STATS_W    = 16;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] write_data;
        logic              hit;
        logic [ADDR_W-1:0] idx;
    } req_t;

    // Conflicting direction, or any real transfer that misses the register window.
    function automatic logic req_is_error(input req_t r);
        return (r.read && r.write) || ((r.read || r.write) && !r.hit);
    endfunction

    function automatic logic req_is_read(input req_t r);
        return r.read && !r.write && r.hit;
    endfunction

    function automatic logic req_is_write(input req_t r);
        return r.write && !r.read && r.hit;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple valid/ready register bus between a master and slave_reg.
interface bus_if;
    logic        valid;
    logic        read;
    logic        write;
    logic [15:0] addr;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;
    logic        error;

    modport master (
        output valid, read, write, addr, write_data,
        input  ready, read_data, error
    );

    modport slave (
        input  valid, read, write, addr, write_data,
        output ready, read_data, error
    );
endinterface

// File: rtl/slave_reg_file.sv
// NUM_REGS x 32-bit storage: synchronous write, asynchronous read, register 0 tap.
module slave_reg_file #(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_idx,
    input  logic [31:0] wr_data,
    input  logic [15:0] rd_idx,
    output logic [31:0] rd_data,
    output logic [31:0] reg0_q
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx < 16'(NUM_REGS))) begin
            regs[wr_idx[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = (rd_idx < 16'(NUM_REGS)) ? regs[rd_idx[AW-1:0]] : '0;
    assign reg0_q  = regs[0];

endmodule

// File: rtl/slave_reg.sv
// Bus slave with a word-addressed register file and programmable wait states.
// Optional build macro SLAVE_REG_STATS_EN adds saturating write/read/error counters.
module slave_reg
    import slave_reg_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h0010,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    bus_if.slave               busa,
    output logic [DATA_W-1:0]  reg0_q
`ifdef SLAVE_REG_STATS_EN
    ,
    output logic [STATS_W-1:0] wr_count,
    output logic [STATS_W-1:0] rd_count,
    output logic [STATS_W-1:0] err_count
`endif
);

    localparam logic [16:0] END_ADDR  = 17'(BASE_ADDR) + 17'(WORD_BYTES * NUM_REGS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t             state;
    req_t               req;
    req_t               req_in;
    req_t               rd_req;
    logic [3:0]         wait_cnt;
    logic [DATA_W-1:0]  rd_data;
    logic               wr_en;

    always_comb begin
        req_in            = '0;
        req_in.addr       = busa.addr;
        req_in.read       = busa.read;
        req_in.write      = busa.write;
        req_in.write_data = busa.write_data;
        req_in.hit        = (busa.addr[1:0] == 2'b00) && (busa.addr >= BASE_ADDR) &&
                            ({1'b0, busa.addr} < END_ADDR);
        req_in.idx        = (busa.addr - BASE_ADDR) >> 2;
    end

    // With zero wait states the read is loaded on the capture edge, so look at the incoming request.
    assign rd_req = (state == S_IDLE) ? req_in : req;
    assign wr_en  = (state == S_RESP) && req_is_write(req);

    slave_reg_file #(
        .NUM_REGS (NUM_REGS)
    ) u_file (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (req.idx),
        .wr_data (req.write_data),
        .rd_idx  (rd_req.idx),
        .rd_data (rd_data),
        .reg0_q  (reg0_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            req            <= '0;
            wait_cnt       <= '0;
            busa.ready     <= 1'b0;
            busa.error     <= 1'b0;
            busa.read_data <= '0;
        end else begin
            busa.ready <= 1'b0;
            busa.error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (busa.valid) begin
                        req      <= req_in;
                        wait_cnt <= WAIT_LOAD;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_RESP;
                            if (req_is_read(req_in)) busa.read_data <= rd_data;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                        if (req_is_read(req)) busa.read_data <= rd_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    busa.ready <= 1'b1;
                    busa.error <= req_is_error(req);
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SLAVE_REG_STATS_EN
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else if (state == S_RESP) begin
            if (req_is_error(req))      err_count <= sat_inc(err_count);
            else if (req_is_write(req)) wr_count  <= sat_inc(wr_count);
            else if (req_is_read(req))  rd_count  <= sat_inc(rd_count);
        end
    end
`endif

endmodule

// File: tb/tb_slave_reg.sv
// Scoreboard bench for slave_reg: WAIT_CYCLES=1 instance for transfers, WAIT_CYCLES=0 for back-to-back.
module tb_slave_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] reg0_1, reg0_0;
`ifdef SLAVE_REG_STATS_EN
    logic [15:0] wr1, rd1, er1, wr0, rd0, er0;
`endif

    always #5 clk = ~clk;

    bus_if bus1();
    bus_if bus0();

    slave_reg #(.NUM_REGS(8), .BASE_ADDR(16'h0010), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .busa(bus1), .reg0_q(reg0_1)
`ifdef SLAVE_REG_STATS_EN
        , .wr_count(wr1), .rd_count(rd1), .err_count(er1)
`endif
    );

    slave_reg #(.NUM_REGS(8), .BASE_ADDR(16'h0010), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .busa(bus0), .reg0_q(reg0_0)
`ifdef SLAVE_REG_STATS_EN
        , .wr_count(wr0), .rd_count(rd0), .err_count(er0)
`endif
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] reg0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          resp_cnt = 0;
    logic [31:0] model [8];
    logic [31:0] last_rd;
    int          n_wr = 0, n_rd = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus1.ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_error", {31'd0, bus1.error}, {31'd0, mon_e.err});
                check("resp_rdata", bus1.read_data, mon_e.rdata);
                check("resp_reg0", reg0_1, mon_e.reg0);
            end
            resp_cnt++;
        end
    end

    task automatic xfer(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
        logic hit, err;
        int   idx, start, n;
        hit = (a[1:0] == 2'b00) && (a >= 16'h0010) && (a < 16'h0030);
        idx = int'((a - 16'h0010) >> 2);
        err = (rd && wr) || ((rd || wr) && !hit);
        if (err) n_err++;
        else if (wr) begin model[idx] = d; n_wr++; end
        else if (rd) begin last_rd = model[idx]; n_rd++; end
        sb.push_back('{err, last_rd, model[0]});
        @(negedge clk);
        bus1.valid = 1'b1; bus1.read = rd; bus1.write = wr;
        bus1.addr = a; bus1.write_data = d;
        start = resp_cnt;
        @(posedge clk);
        n = 0;
        while (resp_cnt == start && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("latency", n, 3);
        bus1.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra;
        int          rdy_seen;
        bus1.valid = 0; bus1.read = 0; bus1.write = 0; bus1.addr = 0; bus1.write_data = 0;
        bus0.valid = 0; bus0.read = 0; bus0.write = 0; bus0.addr = 0; bus0.write_data = 0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        last_rd = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus1.ready}, 32'd0);
        check("rst_error", {31'd0, bus1.error}, 32'd0);
        check("rst_rdata", bus1.read_data, 32'd0);
        check("rst_reg0", reg0_1, 32'd0);
        check("rst_ready0", {31'd0, bus0.ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        xfer(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 16'h0014, 32'h12345678);
        xfer(1'b1, 1'b0, 16'h0014, 32'h0);
        xfer(1'b1, 1'b0, 16'h0030, 32'h0);
        xfer(1'b0, 1'b1, 16'h0012, 32'hFFFF0000);
        xfer(1'b1, 1'b0, 16'h0010, 32'h0);
        xfer(1'b0, 1'b0, 16'h0000, 32'h0);
        xfer(1'b1, 1'b1, 16'h0014, 32'h55555555);
        xfer(1'b0, 1'b1, 16'h002C, 32'h0BADCAFE);
        xfer(1'b1, 1'b0, 16'h002C, 32'h0);
        xfer(1'b1, 1'b0, 16'h000C, 32'h0);
        xfer(1'b1, 1'b0, 16'h0014, 32'h0);

        for (int i = 0; i < 16; i++) begin
            ra = 16'h0008 + 16'($urandom_range(0, 12)) * 16'd4;
            if ($urandom_range(0, 7) == 0) ra = ra + 16'd2;
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
        end

`ifdef SLAVE_REG_STATS_EN
        check("wr_count", {16'd0, wr1}, n_wr);
        check("rd_count", {16'd0, rd1}, n_rd);
        check("err_count", {16'd0, er1}, n_err);
`endif

        // Zero wait states, valid held for six edges: responses on alternate cycles.
        @(negedge clk);
        bus0.valid = 1'b1; bus0.read = 1'b0; bus0.write = 1'b1;
        bus0.addr = 16'h0010; bus0.write_data = 32'h0BADF00D;
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 5) bus0.valid = 1'b0;
            check($sformatf("b2b_ready_%0d", i), {31'd0, bus0.ready}, {31'd0, (i % 2) == 1 && i < 6});
            if (bus0.ready) begin
                rdy_seen++;
                check("b2b_error", {31'd0, bus0.error}, 32'd0);
            end
        end
        check("b2b_count", rdy_seen, 3);
        check("b2b_reg0", reg0_0, 32'h0BADF00D);

        bus0.valid = 1'b1; bus0.read = 1'b1; bus0.write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus0.valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w0_read_ready", {31'd0, bus0.ready}, 32'd1);
        check("w0_read_data", bus0.read_data, 32'h0BADF00D);

        // Reset during S_WAIT aborts the write and clears storage.
        @(negedge clk);
        bus1.valid = 1'b1; bus1.read = 1'b0; bus1.write = 1'b1;
        bus1.addr = 16'h0010; bus1.write_data = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        bus1.valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_ready", {31'd0, bus1.ready}, 32'd0);
        check("abort_error", {31'd0, bus1.error}, 32'd0);
        check("abort_reg0", reg0_1, 32'd0);
        check("abort_reg0_w0", reg0_0, 32'd0);
        sb.delete();
        for (int i = 0; i < 8; i++) model[i] = '0;
        last_rd = '0;
        #2;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_abort_idle", {31'd0, bus1.ready}, 32'd0);
        xfer(1'b1, 1'b0, 16'h0010, 32'h0);
        xfer(1'b1, 1'b0, 16'h0014, 32'h0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_reg.md
Name: slave_reg

Overview:
- Bus slave that terminates transactions issued by the master on `bus_if`.
- Contains a small word-addressed register file, fixed at build time in size and base address.
- Inserts a programmable number of wait states, then returns `ready`, `read_data` and `error`.
- Sits directly downstream of the master. It is the consumer of the write 0xDEADBEEF to 0x0010 and the null transfers that follow it.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (2..64).
- BASE_ADDR, 16'h0010, byte address of register 0; must be word aligned.
- WAIT_CYCLES, 1, wait states between acceptance and response (0..15).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- busa  interface  bus_if.slave  inputs valid, read, write, addr[15:0], write_data[31:0]; outputs ready, read_data[31:0], error.
- reg0_q  output  32  live value of register 0, for observation and integration.

Behaviour:
- Reset values (the block is reset with reset, asynchronous, active-low; clock is clk):
  - state = S_IDLE; all registers = 0.
  - ready = 0, error = 0, read_data = 0, reg0_q = 0.
- FSM states: S_IDLE, S_WAIT, S_RESP. The state is registered; ready and error are decoded from the registered state and flags.
- S_IDLE:
  - If valid = 1 at a posedge, capture addr, read, write and write_data into the request latches.
  - Next state is S_WAIT when WAIT_CYCLES > 0, else S_RESP.
  - Load the wait counter with WAIT_CYCLES-1.
- S_WAIT: decrement the counter each cycle. Go to S_RESP on the edge where the counter equals 0.
- S_RESP:
  - ready = 1 for exactly one cycle; error = err flag. Next state is S_IDLE.
  - Latency: valid sampled at edge k gives ready high in the cycle after edge k+1+WAIT_CYCLES.
- Address decode, done at capture and registered with the request:
  - hit = addr[1:0] == 0 && addr >= BASE_ADDR && addr < BASE_ADDR + 4*NUM_REGS.
  - idx = (addr - BASE_ADDR) >> 2, using 16-bit unsigned arithmetic. Values below BASE_ADDR are not hits, so no wrap can alias.
- Transfer classification:
  - write=1, read=0, hit: register[idx] <= write_data at the posedge ending S_RESP; error = 0.
  - read=1, write=0, hit: read_data <= register[idx], loaded on entry to S_RESP and held until the next read response; error = 0.
  - read=0, write=0 (null transfer): ready is returned, error = 0, no state change, read_data unchanged.
  - read=1 and write=1, or (read|write) with !hit: error = 1, no register write, read_data unchanged.
- A read that immediately follows a write to the same index returns the new value.
- Inputs are ignored outside S_IDLE. If valid drops during S_WAIT or S_RESP, the captured transaction still completes.
- A master holding valid high continuously gets back-to-back transactions, with at least one S_IDLE cycle between responses.
- Reset asserted mid-transaction: abort immediately to S_IDLE, clear all registers, drop ready and error; no partial write.

Optional Feature:
- Macro: SLAVE_REG_STATS_EN.
- Defined:
  - Adds output ports wr_count[15:0], rd_count[15:0] and err_count[15:0].
  - Each counter increments in the S_RESP cycle of a successful write, a successful read, or an errored transfer respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Null transfers are not counted.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package slave_reg_pkg holds:
  - the state typedef (enum logic [1:0] S_IDLE=0, S_WAIT=1, S_RESP=2);
  - the request struct (addr, read, write, write_data, hit, idx);
  - the constants WORD_BYTES=4 and STATS_W=16.
- One sub-module, slave_reg_file: NUM_REGS x 32 storage with synchronous write enable/index/data, asynchronous read index/data, and a reg0 tap.
- The FSM, decode and wait counter stay in slave_reg.

Test Plan:
- Write 0xDEADBEEF to 0x0010 with WAIT_CYCLES=1 and valid held high → ready high 2 cycles after acceptance, error=0, reg0_q=0xDEADBEEF.
- Write 0x12345678 to 0x0014, then read 0x0014 → read response read_data=0x12345678, error=0.
- Read 0x0030 (one past the end with NUM_REGS=8), then write 0x0012 (misaligned) → both responses error=1, registers unchanged.
- Null transfer (valid=1, read=0, write=0, addr=0) → ready after WAIT_CYCLES+1, error=0, read_data unchanged.
- WAIT_CYCLES=0 with valid held high for 6 cycles → ready on every second cycle (3 responses); reset pulsed during S_WAIT → ready=0 and reg0_q=0 immediately.
- With SLAVE_REG_STATS_EN: 2 writes, 1 read, 1 error → wr_count=2, rd_count=1, err_count=1.
